// File: rtl/voucher_vend_ctrl.sv
// Coin-slot arbiter and dispense sequencer that sits in front of the dime/quarter counter FSM.
// Every output comes from a flop loaded from next-state, so no input reaches an output combinationally.
module voucher_vend_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TMR_W       = 4,
  parameter int VCNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dime_req,
  output logic              dime_ack,
  input  logic              qtr_req,
  output logic              qtr_ack,
  output logic              cnt_enable,
  output logic              cnt_coin,
  output logic              cnt_clear_n,
  input  logic              cnt_dollar,
  input  logic              cnt_nickel,
  output logic              vch_req,
  input  logic              vch_ack,
  output logic              nkl_req,
  input  logic              nkl_ack,
  output logic              busy,
  output logic              fault,
  output logic [VCNT_W-1:0] vouchers
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_VREQ,
    S_NREQ,
    S_FAULT
  } state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);

  generate
    if ((2 ** TMR_W) <= ACK_TIMEOUT || ACK_TIMEOUT < 1) begin : g_bad_param
      $error("voucher_vend_ctrl: TMR_W too narrow for ACK_TIMEOUT");
    end
  endgenerate

  state_t              state_q, state_d;
  logic                rr_q, rr_d;       // 1 = dime has priority on a tie
  logic                coin_q, coin_d;   // 1 = dime
  logic                dol_q, dol_d;
  logic                nkl_q, nkl_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;

  logic en_q, dack_q, qack_q, vreq_q, nreq_q, busy_q, fault_q, clr_n_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    coin_d  = coin_q;
    dol_d   = dol_q;
    nkl_d   = nkl_q;
    tmr_d   = tmr_q;
    vcnt_d  = vcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (dime_req || qtr_req) begin
          coin_d  = dime_req && (!qtr_req || rr_q);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dol_d   = cnt_dollar;
        nkl_d   = cnt_nickel;
        rr_d    = ~rr_q;
        tmr_d   = '0;
        state_d = cnt_dollar ? S_VREQ : S_IDLE;
      end
      S_VREQ: begin
        // an ack on the final allowed cycle still wins over the timeout
        if (vch_ack) begin
          if (vcnt_q != {VCNT_W{1'b1}}) vcnt_d = vcnt_q + VCNT_W'(1);
          tmr_d   = '0;
          state_d = nkl_q ? S_NREQ : S_IDLE;
        end else if (tmr_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_NREQ: begin
        if (nkl_ack) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q    <= 1'b1;
      coin_q  <= 1'b0;
      dol_q   <= 1'b0;
      nkl_q   <= 1'b0;
      tmr_q   <= '0;
      vcnt_q  <= '0;
      en_q    <= 1'b0;
      dack_q  <= 1'b0;
      qack_q  <= 1'b0;
      vreq_q  <= 1'b0;
      nreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      coin_q  <= coin_d;
      dol_q   <= dol_d;
      nkl_q   <= nkl_d;
      tmr_q   <= tmr_d;
      vcnt_q  <= vcnt_d;
      en_q    <= (state_d == S_ISSUE);
      dack_q  <= (state_d == S_ISSUE) &&  coin_d;
      qack_q  <= (state_d == S_ISSUE) && !coin_d;
      vreq_q  <= (state_d == S_VREQ);
      nreq_q  <= (state_d == S_NREQ);
      busy_q  <= (state_d != S_IDLE);
      fault_q <= (state_d == S_FAULT);
      clr_n_q <= (state_d != S_FAULT);
    end
  end

  assign dime_ack    = dack_q;
  assign qtr_ack     = qack_q;
  assign cnt_enable  = en_q;
  assign cnt_coin    = coin_q;
  assign cnt_clear_n = clr_n_q;
  assign vch_req     = vreq_q;
  assign nkl_req     = nreq_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign vouchers    = vcnt_q;

endmodule

// File: tb/tb_voucher_vend_ctrl.sv
// Scoreboard bench for voucher_vend_ctrl: expected coins queued at stimulus time, popped at each issue.
module tb_voucher_vend_ctrl;

  logic       clk, reset;
  logic       dime_req, dime_ack, qtr_req, qtr_ack;
  logic       cnt_enable, cnt_coin, cnt_clear_n, cnt_dollar, cnt_nickel;
  logic       vch_req, vch_ack, nkl_req, nkl_ack, busy, fault;
  logic [7:0] vouchers;

  voucher_vend_ctrl #(.ACK_TIMEOUT(15), .TMR_W(4), .VCNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .dime_req(dime_req), .dime_ack(dime_ack),
    .qtr_req(qtr_req), .qtr_ack(qtr_ack),
    .cnt_enable(cnt_enable), .cnt_coin(cnt_coin), .cnt_clear_n(cnt_clear_n),
    .cnt_dollar(cnt_dollar), .cnt_nickel(cnt_nickel),
    .vch_req(vch_req), .vch_ack(vch_ack),
    .nkl_req(nkl_req), .nkl_ack(nkl_ack),
    .busy(busy), .fault(fault), .vouchers(vouchers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic coin;
    logic dol;
    logic nkl;
  } coin_t;

  coin_t exp_q[$];
  int    en_cyc[$];
  int    n_chk, n_err, cyc;
  int    dime_left, qtr_left, vexp;
  int    vdly, ndly, vcyc, ncyc, vrun, nrun;
  int    vlast, nfirst, nlast, qack_cyc, n_en, n_dack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic c, input logic d, input logic n);
    coin_t e;
    e.coin = c; e.dol = d; e.nkl = n;
    exp_q.push_back(e);
  endtask

  // One clock; models the slot requesters, dispensers and counter outputs.
  task automatic tick();
    logic  da, qa, va;
    coin_t e;
    da = dime_ack; qa = qtr_ack; va = vch_req && vch_ack;
    @(posedge clk); #1;
    cyc++;
    if (da && dime_left > 0) dime_left--;
    if (qa && qtr_left > 0) qtr_left--;
    if (va && vexp != 255) vexp++;
    dime_req   = (dime_left > 0);
    qtr_req    = (qtr_left > 0);
    cnt_dollar = 1'b0;
    cnt_nickel = 1'b0;
    if (cnt_enable) begin
      n_en++;
      en_cyc.push_back(cyc);
      if (dime_ack) n_dack++;
      if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("coin", cnt_coin, e.coin);
        chk("slot_ack", {dime_ack, qtr_ack}, e.coin ? 2 : 1);
        cnt_dollar = e.dol;
        cnt_nickel = e.nkl;
      end
    end else if (dime_ack || qtr_ack) chk("ack_without_enable", 1, 0);
    if (qtr_ack) qack_cyc = cyc;
    if (vch_req) begin vcyc++; vlast = cyc; end
    else begin if (vcyc > 0) vrun = vcyc; vcyc = 0; end
    if (nkl_req) begin ncyc++; nlast = cyc; if (ncyc == 1) nfirst = cyc; end
    else begin if (ncyc > 0) nrun = ncyc; ncyc = 0; end
    vch_ack = vch_req && vdly != 0 && vcyc == vdly;
    nkl_ack = nkl_req && ndly != 0 && ncyc == ndly;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    dime_left = 0; qtr_left = 0;
    exp_q.delete();
    tick();
    vexp = 0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_clear_n"}, cnt_clear_n, 0);
    chk({tag, "_vouchers"}, vouchers, 0);
    chk({tag, "_reqs"}, {vch_req, nkl_req, cnt_enable, dime_ack, qtr_ack, cnt_coin}, 0);
    reset = 1'b1;
    tick();
    chk({tag, "_clear_n_rel"}, cnt_clear_n, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy && exp_q.size() == 0 && dime_left == 0 && qtr_left == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk({tag, "_wait_idle"}, 0, 1);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; vexp = 0;
    vdly = 0; ndly = 0; vcyc = 0; ncyc = 0; vrun = 0; nrun = 0;
    dime_left = 0; qtr_left = 0; n_en = 0; n_dack = 0;
    reset = 1'b0; dime_req = 0; qtr_req = 0; cnt_dollar = 0; cnt_nickel = 0;
    vch_ack = 0; nkl_ack = 0;
    tick(); tick();
    do_reset("rst0");

    // 1: three dimes, no dollar
    n_en = 0; n_dack = 0; vrun = 0; en_cyc.delete();
    for (int i = 0; i < 3; i++) push(1, 0, 0);
    dime_left = 3; dime_req = 1;
    wait_idle("t1", 40);
    chk("t1_enables", n_en, 3);
    chk("t1_dime_acks", n_dack, 3);
    chk("t1_no_vch", vrun, 0);
    for (int i = 0; i + 1 < en_cyc.size(); i++) chk("t1_gap", en_cyc[i+1] - en_cyc[i], 2);

    // 2: both slots held, round robin D,Q,D,Q
    do_reset("rst2");
    n_en = 0;
    push(1, 0, 0); push(0, 0, 0); push(1, 0, 0); push(0, 0, 0);
    dime_left = 2; qtr_left = 2; dime_req = 1; qtr_req = 1;
    wait_idle("t2", 40);
    chk("t2_enables", n_en, 4);

    // 3: dollar+nickel; qtr held must wait for IDLE
    do_reset("rst3");
    vdly = 3; ndly = 2; vrun = 0; nrun = 0; qack_cyc = 0;
    push(1, 1, 1); push(0, 0, 0);
    dime_left = 1; qtr_left = 1; dime_req = 1; qtr_req = 1;
    wait_idle("t3", 60);
    chk("t3_vch_len", vrun, 3);
    chk("t3_nkl_len", nrun, 2);
    chk("t3_nkl_follows", nfirst, vlast + 1);
    chk("t3_qtr_after_nkl", qack_cyc > nlast, 1);
    chk("t3_vouchers", vouchers, vexp);
    chk("t3_vouchers_one", vouchers, 1);

    // 4: voucher never acked -> fault after 15 cycles
    do_reset("rst4");
    vdly = 0; ndly = 0; vrun = 0;
    push(1, 1, 0);
    dime_left = 1; qtr_left = 1; dime_req = 1; qtr_req = 1;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (fault) begin hit = 1; break; end
      end
      if (!hit) chk("t4_reach_fault", 0, 1);
    end
    chk("t4_vch_len", vrun, 15);
    chk("t4_clear_n", cnt_clear_n, 0);
    chk("t4_busy", busy, 1);
    chk("t4_vch_dropped", vch_req, 0);
    repeat (10) tick();
    chk("t4_fault_sticky", fault, 1);
    chk("t4_qtr_unacked", qtr_left, 1);
    chk("t4_vouchers", vouchers, 0);

    // 5: reset while in NREQ, then resume
    do_reset("rst5");
    vdly = 1; ndly = 0;
    push(1, 1, 1);
    dime_left = 1; dime_req = 1;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (nkl_req) begin hit = 1; break; end
      end
      if (!hit) chk("t5_reach_nreq", 0, 1);
    end
    chk("t5_vouchers_pre", vouchers, 1);
    do_reset("t5_midreset");
    n_en = 0; ndly = 2;
    push(1, 0, 0);
    dime_left = 1; dime_req = 1;
    wait_idle("t5_resume", 30);
    chk("t5_resume_enables", n_en, 1);

    // 6: voucher counter saturation
    do_reset("rst6");
    vdly = 1; ndly = 0;
    for (int i = 0; i < 260; i++) push(1, 1, 0);
    dime_left = 260; dime_req = 1;
    wait_idle("t6", 2000);
    chk("t6_vouchers_model", vouchers, vexp);
    chk("t6_vouchers_sat", vouchers, 255);
    chk("t6_no_fault", fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
